// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button conditioner: sync, debounce, press pulses, auto-repeat
// Mode key (top bit) pulses pre-empt all lower-key pulses in the same cycle.
module key_conditioner #(
  parameter int                N_KEYS          = 5,
  parameter bit                ACTIVE_LOW_IN   = 1'b1,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 5'b01001,
  parameter int                REPEAT_DELAY    = 25000000,
  parameter int                REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] sw_pulse,
  output logic [N_KEYS-1:0] sw_level
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX);

  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [CW-1:0]     cnt [N_KEYS];
  logic [HW-1:0]     hc  [N_KEYS];
  logic [N_KEYS-1:0] rep;

  logic [N_KEYS-1:0] press_evt;
  logic [N_KEYS-1:0] rep_evt;
  logic [N_KEYS-1:0] raw_pulse;
  logic [N_KEYS-1:0] pulse_nxt;
  logic              mode_fire;

  assign pressed = ACTIVE_LOW_IN ? ~key_in : key_in;

  always_comb begin
    press_evt = '0;
    rep_evt   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      press_evt[i] = s2[i] & ~sw_level[i] & (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      rep_evt[i]   = REPEAT_MASK[i] & sw_level[i] &
                     (rep[i] ? (hc[i] == HW'(REPEAT_PERIOD - 1))
                             : (hc[i] == HW'(REPEAT_DELAY - 1)));
    end
    raw_pulse = press_evt | rep_evt;
    mode_fire = raw_pulse[N_KEYS-1];
    // A mode pulse drops every coincident lower-key pulse outright.
    pulse_nxt = mode_fire ? {1'b1, {(N_KEYS-1){1'b0}}} : raw_pulse;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      sw_level <= '0;
      sw_pulse <= '0;
      rep      <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
        hc[i]  <= '0;
      end
    end else begin
      s1       <= pressed;
      s2       <= s1;
      sw_pulse <= pulse_nxt;
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2[i] == sw_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          sw_level[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end

        // Hold timer restarts on release, on the press itself, and when the mode key fires.
        if (!REPEAT_MASK[i] || !sw_level[i] || (mode_fire && (i < N_KEYS - 1))) begin
          hc[i]  <= '0;
          rep[i] <= 1'b0;
        end else if (rep_evt[i]) begin
          hc[i]  <= '0;
          rep[i] <= 1'b1;
        end else begin
          hc[i] <= hc[i] + HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner
// Stimulus queues expected (cycle, pulse) pairs; a negedge monitor pops and compares.
module tb_key_conditioner;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] sw_pulse;
  logic [N-1:0] sw_level;

  key_conditioner #(
    .N_KEYS(5), .ACTIVE_LOW_IN(1'b1), .DEBOUNCE_CYCLES(4),
    .REPEAT_MASK(5'b01001), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .sw_pulse(sw_pulse), .sw_level(sw_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] val;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
  endtask

  task automatic expect_pulse(input int c, input logic [N-1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_pulse", 32'(sw_pulse), 32'd0);
      check("rst_level", 32'(sw_level), 32'd0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        check("pulse_missing", 32'd0, 32'(mon_e.val));
      end
      if (sw_pulse != '0) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          mon_e = q.pop_front();
          check("pulse_value", 32'(sw_pulse), 32'(mon_e.val));
        end else begin
          check("unexpected_pulse", 32'(sw_pulse), 32'd0);
        end
      end
    end
  end

  int c;
  int f;

  initial begin
    #1;
    check("por_pulse", 32'(sw_pulse), 32'd0);
    check("por_level", 32'(sw_level), 32'd0);
    step(3);
    rst = 1'b0;
    step(5);
    #3 rst = 1'b1;
    #1 check("midcycle_rst_pulse", 32'(sw_pulse), 32'd0);
    step(30);
    rst = 1'b0;
    step(30);
    check("idle_level", 32'(sw_level), 32'd0);

    // key 0 held: press, three repeats, one more repeat while release debounces
    c = cyc;
    key_in[0] = 1'b0;
    expect_pulse(c + 6, 5'b00001);
    expect_pulse(c + 26, 5'b00001);
    expect_pulse(c + 31, 5'b00001);
    expect_pulse(c + 36, 5'b00001);
    expect_pulse(c + 41, 5'b00001);
    step(5);
    check("k0_level_before", 32'(sw_level[0]), 32'd0);
    step(1);
    check("k0_level_rise", 32'(sw_level[0]), 32'd1);
    step(30);
    key_in[0] = 1'b1;
    step(5);
    check("k0_level_hold", 32'(sw_level[0]), 32'd1);
    step(1);
    check("k0_level_fall", 32'(sw_level[0]), 32'd0);
    step(30);

    // key 2 bounces, then settles low
    for (int i = 0; i < 5; i++) begin
      key_in[2] = 1'b0;
      step(3);
      key_in[2] = 1'b1;
      step(1);
    end
    c = cyc;
    key_in[2] = 1'b0;
    expect_pulse(c + 6, 5'b00100);
    step(5);
    check("k2_level_before", 32'(sw_level[2]), 32'd0);
    step(1);
    check("k2_level_rise", 32'(sw_level[2]), 32'd1);
    step(34);
    key_in[2] = 1'b1;
    step(10);
    check("k2_level_fall", 32'(sw_level[2]), 32'd0);

    // keys 4 and 0 together: mode wins, key 0 repeat counted from mode pulse
    c = cyc;
    key_in[4] = 1'b0;
    key_in[0] = 1'b0;
    expect_pulse(c + 6, 5'b10000);
    expect_pulse(c + 26, 5'b00001);
    expect_pulse(c + 31, 5'b00001);
    step(6);
    check("k40_level", 32'(sw_level), 32'h11);
    step(20);
    key_in = '1;
    step(20);
    check("k40_released", 32'(sw_level), 32'd0);

    // reset while key 0 held, then re-press after release of rst
    c = cyc;
    key_in[0] = 1'b0;
    expect_pulse(c + 6, 5'b00001);
    expect_pulse(c + 26, 5'b00001);
    step(28);
    check("k0_held_level", 32'(sw_level[0]), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_level", 32'(sw_level), 32'd0);
    check("async_rst_pulse", 32'(sw_pulse), 32'd0);
    step(3);
    rst = 1'b0;
    f = cyc;
    expect_pulse(f + 6, 5'b00001);
    expect_pulse(f + 26, 5'b00001);
    expect_pulse(f + 31, 5'b00001);
    step(26);
    key_in[0] = 1'b1;
    step(20);

    // key 3 repeating, mode press collides with a repeat
    c = cyc;
    key_in[3] = 1'b0;
    expect_pulse(c + 6, 5'b01000);
    expect_pulse(c + 26, 5'b01000);
    step(25);
    key_in[4] = 1'b0;
    expect_pulse(c + 31, 5'b10000);
    expect_pulse(c + 51, 5'b01000);
    step(7);
    check("k34_level", 32'(sw_level), 32'h18);
    key_in[4] = 1'b1;
    step(19);
    key_in[3] = 1'b1;
    expect_pulse(c + 56, 5'b01000);
    step(20);

    step(10);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
